// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem
//   Instruction memory with a program-load mode and a valid/ready fetch port.
//   After reset the memory is cleared to NOP_WORD one word per cycle (INIT).
//   It then serves fetches (RUN) or accepts program writes (LOAD).
//   Fetches are read synchronously and buffered in a 2-entry response FIFO.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   load_mode                request to enter / stay in program-load mode
//   ld_we, ld_addr, ld_data  load write strobe, word index and data
//   req_valid, req_ready     fetch request handshake
//   req_addr                 fetch address (word or byte, see BYTE_ADDR)
//   resp_valid, resp_ready   response handshake
//   resp_instr, resp_err     fetched word, out-of-range/misaligned flag
//   state                    current mode: 0 INIT, 1 RUN, 2 LOAD
module instr_fetch_mem #(
  parameter int             N         = 24,
  parameter int             DEPTH     = 1024,
  parameter int             AW        = 24,
  parameter int             BYTE_ADDR = 0,
  parameter logic [N-1:0]   NOP_WORD  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_mode,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [N-1:0]  resp_instr,
  output logic          resp_err,
  output logic [1:0]    state
);

  localparam int            CW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DepthA  = AW'(DEPTH);
  localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] clrCnt_q, clrCnt_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          wrPtr_q, wrPtr_d;
  logic          rdPtr_q, rdPtr_d;
  logic          rdValid_q, rdValid_d;
  logic          rdErr_q;
  logic [N-1:0]  rdData_q;
  logic [N-1:0]  fifoData_q [2];
  logic          fifoErr_q [2];
  logic [N-1:0]  mem [DEPTH];

  logic [AW-1:0] fetchIdx;
  logic          fetchErr;
  logic [CW-1:0] rdAddr;
  logic [1:0]    occ;
  logic          accept, respValid, pop, popFifo, popInflight, pushFifo;
  logic [N-1:0]  headData;
  logic          headErr;
  logic          memWe;
  logic [CW-1:0] memWAddr;
  logic [N-1:0]  memWData;

  // Address decode; erroneous fetches still read a harmless in-range word
  // and are replaced by NOP_WORD at the output.
  assign fetchIdx = (BYTE_ADDR != 0) ? (req_addr >> 2) : req_addr;
  assign fetchErr = (fetchIdx >= DepthA) ||
                    ((BYTE_ADDR != 0) && (req_addr[1:0] != 2'b00));
  assign rdAddr   = fetchErr ? '0 : fetchIdx[CW-1:0];

  // The read register holds the newest (in-flight) response. It is served
  // directly when the FIFO is empty, otherwise it moves into the FIFO behind
  // the older entries, which keeps responses in order with 1-cycle latency.
  assign occ         = cnt_q + {1'b0, rdValid_q};
  assign req_ready   = (state_q == RUN) && (occ < 2'd2) && !load_mode;
  assign accept      = req_valid && req_ready;
  assign respValid   = (cnt_q != 2'd0) || rdValid_q;
  assign pop         = respValid && resp_ready;
  assign popFifo     = pop && (cnt_q != 2'd0);
  assign popInflight = pop && (cnt_q == 2'd0);
  assign pushFifo    = rdValid_q && !popInflight;

  assign headData   = (cnt_q != 2'd0) ? fifoData_q[rdPtr_q] : rdData_q;
  assign headErr    = (cnt_q != 2'd0) ? fifoErr_q[rdPtr_q]  : rdErr_q;
  assign resp_valid = respValid;
  assign resp_instr = (respValid && !headErr) ? headData : NOP_WORD;
  assign resp_err   = respValid && headErr;
  assign state      = state_q;

  // Single write port shared by the INIT clear and program loads.
  always_comb begin
    memWe    = 1'b0;
    memWAddr = clrCnt_q;
    memWData = NOP_WORD;
    if (state_q == INIT) begin
      memWe = 1'b1;
    end else if ((state_q == LOAD) && ld_we && (ld_addr < DepthA)) begin
      memWe    = 1'b1;
      memWAddr = ld_addr[CW-1:0];
      memWData = ld_data;
    end
  end

  // Mode sequencing and FIFO bookkeeping.
  always_comb begin
    state_d   = state_q;
    clrCnt_d  = clrCnt_q;
    rdValid_d = accept;
    cnt_d     = cnt_q + {1'b0, pushFifo} - {1'b0, popFifo};
    wrPtr_d   = wrPtr_q ^ pushFifo;
    rdPtr_d   = rdPtr_q ^ popFifo;
    case (state_q)
      INIT: begin
        if (clrCnt_q == LastIdx) begin
          clrCnt_d = '0;
          state_d  = load_mode ? LOAD : RUN;
        end else begin
          clrCnt_d = clrCnt_q + CW'(1);
        end
      end
      RUN: begin
        if (load_mode && (occ == 2'd0)) state_d = LOAD;
      end
      LOAD: begin
        if (!load_mode) state_d = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      clrCnt_q  <= '0;
      cnt_q     <= 2'd0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clrCnt_q  <= clrCnt_d;
      cnt_q     <= cnt_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      rdValid_q <= rdValid_d;
    end
  end

  // Memory array, its read register and FIFO storage carry no reset; the
  // control state above decides whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (memWe) mem[memWAddr] <= memWData;
    if (accept) begin
      rdData_q <= mem[rdAddr];
      rdErr_q  <= fetchErr;
    end
    if (pushFifo) begin
      fifoData_q[wrPtr_q] <= rdData_q;
      fifoErr_q[wrPtr_q]  <= rdErr_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem
//   Directed bench for instr_fetch_mem. Instance A uses word addressing and
//   the default depth; instance B uses byte addressing with a 64-word memory.
//   Both share reset and the load port; each has its own fetch port.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_mode;
  logic        ld_we;
  logic [23:0] ld_addr;
  logic [23:0] ld_data;

  logic        reqValidA, reqReadyA, respValidA, respReadyA, respErrA;
  logic [23:0] reqAddrA, respInstrA;
  logic [1:0]  stateA;
  logic        reqValidB, reqReadyB, respValidB, respReadyB, respErrB;
  logic [23:0] reqAddrB, respInstrB;
  logic [1:0]  stateB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_mem #(
    .N(24), .DEPTH(1024), .AW(24), .BYTE_ADDR(0), .NOP_WORD(24'h000000)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(reqValidA), .req_ready(reqReadyA), .req_addr(reqAddrA),
    .resp_valid(respValidA), .resp_ready(respReadyA),
    .resp_instr(respInstrA), .resp_err(respErrA), .state(stateA)
  );

  instr_fetch_mem #(
    .N(24), .DEPTH(64), .AW(24), .BYTE_ADDR(1), .NOP_WORD(24'h000000)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(reqValidB), .req_ready(reqReadyB), .req_addr(reqAddrB),
    .resp_valid(respValidB), .resp_ready(respReadyB),
    .resp_instr(respInstrB), .resp_err(respErrB), .state(stateB)
  );

  // Single fetch on instance A (sel=0) or B (sel=1). lat is the number of
  // extra negedges after the acceptance edge before resp_valid was seen;
  // -1 means never accepted, 99 means no response.
  task automatic doFetch(input bit sel, input logic [23:0] addr,
                         output logic [23:0] instr, output logic err,
                         output int lat);
    int n;
    @(negedge clk);
    if (sel) begin reqValidB = 1'b1; reqAddrB = addr; end
    else begin reqValidA = 1'b1; reqAddrA = addr; end
    #1;
    n = 0;
    while (!(sel ? reqReadyB : reqReadyA) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!(sel ? reqReadyB : reqReadyA)) begin
      reqValidA = 1'b0; reqValidB = 1'b0;
      instr = 'x; err = 1'bx; lat = -1;
      return;
    end
    @(negedge clk);
    reqValidA = 1'b0; reqValidB = 1'b0;
    #1;
    lat = 0;
    while (!(sel ? respValidB : respValidA) && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    if (!(sel ? respValidB : respValidA)) lat = 99;
    instr = sel ? respInstrB : respInstrA;
    err   = sel ? respErrB : respErrA;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_mode = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    reqValidA = 1'b0; reqAddrA = '0; respReadyA = 1'b1;
    reqValidB = 1'b0; reqAddrB = '0; respReadyB = 1'b1;
    #12;
    checks++; if (stateA !== 2'd0) begin failures++; $display("[TB] FAIL reset_state: got %0d expected 0", stateA); end
    checks++; if (reqReadyA !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected 0", reqReadyA); end
    checks++; if (respValidA !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", respValidA); end
    checks++; if (respErrA !== 1'b0 || respInstrA !== 24'h0) begin failures++; $display("[TB] FAIL reset_resp_data: got err=%b instr=%h expected err=0 instr=000000", respErrA, respInstrA); end
  endtask

  task automatic test_init_length();
    int n;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (stateA == 2'd0 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (n !== 1024) begin failures++; $display("[TB] FAIL init_cycles: got %0d expected 1024", n); end
    checks++; if (stateA !== 2'd1) begin failures++; $display("[TB] FAIL init_to_run: got %0d expected 1", stateA); end
  endtask

  task automatic test_run_fetch();
    logic [23:0] instr; logic err; int lat;
    doFetch(1'b0, 24'd5, instr, err, lat);
    checks++; if (lat !== 0) begin failures++; $display("[TB] FAIL fetch5_latency: got %0d expected 0", lat); end
    checks++; if (instr !== 24'h0 || err !== 1'b0) begin failures++; $display("[TB] FAIL fetch5_data: got instr=%h err=%b expected 000000 err=0", instr, err); end
  endtask

  task automatic test_ignore_we();
    logic [23:0] instr; logic err; int lat;
    @(negedge clk); ld_we = 1'b1; ld_addr = 24'd9; ld_data = 24'h123456;
    @(negedge clk); ld_we = 1'b0;
    doFetch(1'b0, 24'd9, instr, err, lat);
    checks++; if (instr !== 24'h0 || lat !== 0) begin failures++; $display("[TB] FAIL run_we_ignored: got instr=%h lat=%0d expected 000000 lat=0", instr, lat); end
  endtask

  task automatic test_load();
    logic [23:0] instr; logic err; int lat; int n;
    @(negedge clk); respReadyA = 1'b0; reqValidA = 1'b1; reqAddrA = 24'd5;
    @(negedge clk); load_mode = 1'b1;
    #1;
    checks++; if (reqReadyA !== 1'b0) begin failures++; $display("[TB] FAIL load_gates_ready: got %b expected 0", reqReadyA); end
    @(negedge clk); #1;
    checks++; if (stateA !== 2'd1) begin failures++; $display("[TB] FAIL drain_holds_run: got %0d expected 1", stateA); end
    reqValidA = 1'b0; respReadyA = 1'b1;
    n = 0;
    while (stateA != 2'd2 && n < 10) begin @(negedge clk); n++; end
    checks++; if (stateA !== 2'd2) begin failures++; $display("[TB] FAIL enter_load: got %0d expected 2", stateA); end
    @(negedge clk); ld_we = 1'b1; ld_addr = 24'd7;    ld_data = 24'hABCDEF;
    @(negedge clk); ld_we = 1'b1; ld_addr = 24'd1024; ld_data = 24'h555555;
    @(negedge clk); ld_we = 1'b1; ld_addr = 24'd3;    ld_data = 24'h0F0F0F;
    @(negedge clk); ld_we = 1'b0; load_mode = 1'b0;
    n = 0;
    while (stateA != 2'd1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (stateA !== 2'd1) begin failures++; $display("[TB] FAIL leave_load: got %0d expected 1", stateA); end
    doFetch(1'b0, 24'd7, instr, err, lat);
    checks++; if (instr !== 24'hABCDEF || err !== 1'b0 || lat !== 0) begin failures++; $display("[TB] FAIL fetch7_loaded: got instr=%h err=%b lat=%0d expected abcdef err=0 lat=0", instr, err, lat); end
    doFetch(1'b0, 24'd3, instr, err, lat);
    checks++; if (instr !== 24'h0F0F0F || lat !== 0) begin failures++; $display("[TB] FAIL fetch3_loaded: got instr=%h lat=%0d expected 0f0f0f lat=0", instr, lat); end
    doFetch(1'b0, 24'd0, instr, err, lat);
    checks++; if (instr !== 24'h0 || lat !== 0) begin failures++; $display("[TB] FAIL oob_load_dropped: got instr=%h lat=%0d expected 000000 lat=0", instr, lat); end
  endtask

  task automatic test_backpressure();
    int accepts; bit unstable;
    @(negedge clk); respReadyA = 1'b0; reqValidA = 1'b1; reqAddrA = 24'd7;
    accepts = 0; unstable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (respValidA && (respInstrA !== 24'hABCDEF || respErrA !== 1'b0)) unstable = 1'b1;
      if (reqReadyA) accepts++;
      @(negedge clk);
      if (accepts == 1) reqAddrA = 24'd3;
    end
    reqValidA = 1'b0;
    #1;
    checks++; if (accepts !== 2) begin failures++; $display("[TB] FAIL bp_accepts: got %0d expected 2", accepts); end
    checks++; if (unstable !== 1'b0) begin failures++; $display("[TB] FAIL bp_stable: got unstable=%b expected 0", unstable); end
    checks++; if (reqReadyA !== 1'b0 || respValidA !== 1'b1) begin failures++; $display("[TB] FAIL bp_full: got ready=%b valid=%b expected ready=0 valid=1", reqReadyA, respValidA); end
    respReadyA = 1'b1;
    @(negedge clk); #1;
    checks++; if (respValidA !== 1'b1 || respInstrA !== 24'h0F0F0F) begin failures++; $display("[TB] FAIL bp_second: got valid=%b instr=%h expected valid=1 instr=0f0f0f", respValidA, respInstrA); end
    @(negedge clk); #1;
    checks++; if (respValidA !== 1'b0 || reqReadyA !== 1'b1) begin failures++; $display("[TB] FAIL bp_drained: got valid=%b ready=%b expected valid=0 ready=1", respValidA, reqReadyA); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] addrs [4];
    logic [23:0] expd [4];
    bit stalled;
    addrs = '{24'd7, 24'd3, 24'd0, 24'd7};
    expd  = '{24'hABCDEF, 24'h0F0F0F, 24'h000000, 24'hABCDEF};
    stalled = 1'b0;
    @(negedge clk); respReadyA = 1'b1; reqValidA = 1'b1; reqAddrA = addrs[0];
    for (int i = 0; i < 4; i++) begin
      #1;
      if (!reqReadyA) stalled = 1'b1;
      @(negedge clk);
      if (i < 3) reqAddrA = addrs[i+1];
      else reqValidA = 1'b0;
      #1;
      checks++; if (respValidA !== 1'b1 || respInstrA !== expd[i]) begin failures++; $display("[TB] FAIL b2b_resp%0d: got valid=%b instr=%h expected valid=1 instr=%h", i, respValidA, respInstrA, expd[i]); end
    end
    checks++; if (stalled !== 1'b0) begin failures++; $display("[TB] FAIL b2b_no_stall: got stalled=%b expected 0", stalled); end
    @(negedge clk); #1;
    checks++; if (respValidA !== 1'b0) begin failures++; $display("[TB] FAIL b2b_empty: got %b expected 0", respValidA); end
  endtask

  task automatic test_out_of_range();
    logic [23:0] instr; logic err; int lat;
    doFetch(1'b0, 24'd1024, instr, err, lat);
    checks++; if (err !== 1'b1 || instr !== 24'h0 || lat !== 0) begin failures++; $display("[TB] FAIL oob_depth: got err=%b instr=%h lat=%0d expected err=1 instr=000000 lat=0", err, instr, lat); end
    doFetch(1'b0, 24'hFFFFFF, instr, err, lat);
    checks++; if (err !== 1'b1 || instr !== 24'h0) begin failures++; $display("[TB] FAIL oob_max: got err=%b instr=%h expected err=1 instr=000000", err, instr); end
  endtask

  task automatic test_byte_addr();
    logic [23:0] instr; logic err; int lat;
    doFetch(1'b1, 24'h1C, instr, err, lat);
    checks++; if (instr !== 24'hABCDEF || err !== 1'b0 || lat !== 0) begin failures++; $display("[TB] FAIL byte_1c: got instr=%h err=%b lat=%0d expected abcdef err=0 lat=0", instr, err, lat); end
    doFetch(1'b1, 24'h1D, instr, err, lat);
    checks++; if (instr !== 24'h0 || err !== 1'b1) begin failures++; $display("[TB] FAIL byte_misaligned: got instr=%h err=%b expected 000000 err=1", instr, err); end
    doFetch(1'b1, 24'h100, instr, err, lat);
    checks++; if (instr !== 24'h0 || err !== 1'b1) begin failures++; $display("[TB] FAIL byte_oob: got instr=%h err=%b expected 000000 err=1", instr, err); end
    doFetch(1'b1, 24'h0C, instr, err, lat);
    checks++; if (instr !== 24'h0F0F0F || err !== 1'b0) begin failures++; $display("[TB] FAIL byte_0c: got instr=%h err=%b expected 0f0f0f err=0", instr, err); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] instr; logic err; int lat; int n;
    @(negedge clk); respReadyA = 1'b0; reqValidA = 1'b1; reqAddrA = 24'd7;
    repeat (3) @(negedge clk);
    reqValidA = 1'b0;
    #1;
    checks++; if (respValidA !== 1'b1 || reqReadyA !== 1'b0) begin failures++; $display("[TB] FAIL mid_two_buffered: got valid=%b ready=%b expected valid=1 ready=0", respValidA, reqReadyA); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (respValidA !== 1'b0 || stateA !== 2'd0 || reqReadyA !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_async: got valid=%b state=%0d ready=%b expected 0/0/0", respValidA, stateA, reqReadyA); end
    checks++; if (respInstrA !== 24'h0 || respErrA !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_outputs: got instr=%h err=%b expected 000000 err=0", respInstrA, respErrA); end
    load_mode = 1'b1; respReadyA = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (stateA == 2'd0 && n < 2000) begin @(negedge clk); n++; end
    checks++; if (n !== 1024) begin failures++; $display("[TB] FAIL reinit_cycles: got %0d expected 1024", n); end
    checks++; if (stateA !== 2'd2) begin failures++; $display("[TB] FAIL init_to_load: got %0d expected 2", stateA); end
    load_mode = 1'b0;
    n = 0;
    while (stateA != 2'd1 && n < 10) begin @(negedge clk); n++; end
    doFetch(1'b0, 24'd7, instr, err, lat);
    checks++; if (instr !== 24'h0 || err !== 1'b0 || lat !== 0) begin failures++; $display("[TB] FAIL reinit_cleared: got instr=%h err=%b lat=%0d expected 000000 err=0 lat=0", instr, err, lat); end
  endtask

  // Runs the scenarios in order; later ones rely on words 7 and 3 loaded
  // in test_load.
  initial begin
    test_reset();
    test_init_length();
    test_run_fetch();
    test_ignore_we();
    test_load();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_byte_addr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Stops a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter: N, 24, instruction word width in bits.
REQ-002 Parameter: DEPTH, 1024, number of instruction words.
REQ-003 Parameter: AW, 24, width of the fetch and load address ports.
REQ-004 Parameter: BYTE_ADDR, 0, addressing mode: 0 = word index is addr; 1 = word index is addr>>2.
REQ-005 Parameter: NOP_WORD, all-zero N bits, fill value used at init and for error responses.
REQ-006 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-007 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port: load_mode, input, 1, request to enter program-load mode.
REQ-009 Port: ld_we, input, 1, load write strobe.
REQ-010 Port: ld_addr, input, AW, load word address, always a word index regardless of BYTE_ADDR.
REQ-011 Port: ld_data, input, N, load write data.
REQ-012 Port: req_valid, input, 1, fetch request valid.
REQ-013 Port: req_ready, output, 1, fetch request accepted when high together with req_valid.
REQ-014 Port: req_addr, input, AW, fetch address.
REQ-015 Port: resp_valid, output, 1, response valid.
REQ-016 Port: resp_ready, input, 1, consumer accepts the response.
REQ-017 Port: resp_instr, output, N, fetched instruction.
REQ-018 Port: resp_err, output, 1, response flagged as an out-of-range or misaligned fetch.
REQ-019 Port: state, output, 2, current mode: 0 = INIT, 1 = RUN, 2 = LOAD.

Function
REQ-020 The FSM SHALL have three states:
- INIT: writes NOP_WORD to word i on cycle i, for i = 0..DEPTH-1; exits after word DEPTH-1.
- RUN: serves fetches.
- LOAD: accepts load writes.
REQ-021 INIT -> LOAD if load_mode = 1 on the last clear cycle; otherwise INIT -> RUN.
REQ-022 RUN -> LOAD when load_mode = 1 and occupancy = 0; LOAD -> RUN when load_mode = 0.
REQ-023 Occupancy SHALL equal the buffered responses plus the in-flight read (0..2).
REQ-024 req_ready SHALL be 1 only in RUN with occupancy < 2, and SHALL NOT depend combinationally on resp_ready.
REQ-025 In RUN with load_mode = 1, req_ready SHALL be 0 until the drain to LOAD completes.
REQ-026 A fetch is accepted when req_valid and req_ready are both high; it is read synchronously and enters the 2-entry output FIFO the next cycle, so minimum latency is 1 cycle.
REQ-027 Responses SHALL leave in acceptance order; the head is popped when resp_valid and resp_ready are both high.
REQ-028 While resp_valid = 1 and resp_ready = 0, resp_instr and resp_err SHALL hold stable.
REQ-029 Index = req_addr when BYTE_ADDR = 0, or req_addr>>2 when BYTE_ADDR = 1.
REQ-030 resp_err = 1 and resp_instr = NOP_WORD when index >= DEPTH, or when BYTE_ADDR = 1 and req_addr[1:0] != 0.
REQ-031 In LOAD, ld_we = 1 writes ld_data to word ld_addr on the clock edge; a write with ld_addr >= DEPTH SHALL be dropped.
REQ-032 ld_we SHALL be ignored in INIT and RUN.
REQ-033 A push and a pop in the same cycle SHALL leave occupancy unchanged with no data loss; the FIFO wraps around modulo 2.
REQ-034 Memory SHALL be inferable as synchronous single-port-read plus single-port-write RAM; no delays or simulation display statements.

Reset
REQ-035 rst_n = 0 SHALL immediately force state = INIT, req_ready = 0, resp_valid = 0, resp_err = 0, resp_instr = NOP_WORD, FIFO pointers = 0, occupancy = 0, clear counter = 0.
REQ-036 Reset asserted mid-operation SHALL discard in-flight and buffered responses and restart INIT from word 0 after release.
REQ-037 Memory contents are not reset asynchronously; INIT rewrites them.

Verification
REQ-038 Release reset with load_mode = 0 -> state = INIT for exactly DEPTH cycles, then RUN; a fetch of addr 5 returns NOP_WORD with resp_err = 0.
REQ-039 Enter LOAD, write 0xABCDEF at word 7, return to RUN -> fetch addr 7 (BYTE_ADDR = 0) returns 0xABCDEF one cycle after acceptance.
REQ-040 Hold resp_ready = 0 with req_valid = 1 -> exactly 2 accepts, then req_ready = 0 and the outputs stay stable; release resp_ready -> 2 responses in order, then req_ready = 1 again.
REQ-041 Fetch addr DEPTH -> resp_err = 1 with NOP_WORD; with BYTE_ADDR = 1, fetch addr 0x1D -> resp_err = 1, fetch addr 0x1C returns word 7.
REQ-042 Assert rst_n = 0 with 2 responses buffered -> resp_valid drops immediately; after release, state = INIT and the clear restarts from word 0.
